// File: rtl/thor2022_regsel_stage_pkg.sv
// Thor2022_pkg: opcode/func enums, instruction formats and default SP constants
package Thor2022_pkg;
  typedef enum logic [6:0] {R2 = 7'd2, VM = 7'd82} opcode_t;
  typedef enum logic [4:0] {VMCNTPOP = 5'd0, VMFIRST = 5'd1, VMLAST = 5'd2} vm_func_t;
  typedef struct packed {
    logic [6:0] func;
    logic [5:0] Rc;
    logic [5:0] Rb;
    logic [5:0] Ra;
    logic [6:0] opcode;
  } r3_t;
  typedef struct packed {
    logic [4:0] func;
    logic [4:0] Rc;
    logic [4:0] Rb;
    logic [4:0] Ra;
    logic [4:0] Rt;
    logic [6:0] opcode;
  } r2_t;
  typedef union packed {
    r3_t r3;
    r2_t r2;
    logic [31:0] raw;
  } Instruction;
  localparam int SPREG = 31;
  localparam int SPBASE = 44;
endpackage

// File: rtl/thor2022_regsel_stage_src_remap.sv
// thor2022_src_remap: per-port source field select followed by banked stack pointer remap
module thor2022_src_remap
  import Thor2022_pkg::*;
#(
  parameter int PORT = 0,
  parameter int REGW = 6,
  parameter int SPREG = Thor2022_pkg::SPREG,
  parameter int SPBASE = Thor2022_pkg::SPBASE,
  parameter int NSPBANK = 4
) (
  input  Instruction        ir,
  input  logic [2:0]        sp_sel,
  output logic [REGW-1:0]   idx
);
  logic [REGW-1:0] f3, f2, vm, sel;
  logic vm_cnt, bank;
  always_comb begin
    f3 = PORT == 0 ? REGW'(ir.r3.Ra) : PORT == 1 ? REGW'(ir.r3.Rb) : PORT == 2 ? REGW'(ir.r3.Rc) : '0;
    f2 = PORT == 0 ? REGW'(ir.r2.Ra) : PORT == 1 ? REGW'(ir.r2.Rb) : PORT == 2 ? REGW'(ir.r2.Rc) : '0;
    vm = REGW'({3'b100, ir.raw[17:15]});
    vm_cnt = ir.r2.func == VMCNTPOP || ir.r2.func == VMFIRST || ir.r2.func == VMLAST;
    sel = ir.r3.opcode == R2 ? f3 : (ir.r3.opcode == VM && PORT == 1) ? (vm_cnt ? vm : '0) : f2;
    bank = sel == REGW'(SPREG) && sp_sel != 3'd0 && int'(sp_sel) <= NSPBANK;
    idx = bank ? REGW'(SPBASE + int'(sp_sel) - 1) : sel;
  end
endmodule

// File: rtl/thor2022_regsel_stage.sv
// thor2022_regsel_stage: source select/remap stage with optional busy scoreboard (THOR2022_REGSEL_SCOREBOARD_EN)
module thor2022_regsel_stage
  import Thor2022_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int REGW = 6,
  parameter int SPREG = Thor2022_pkg::SPREG,
  parameter int SPBASE = Thor2022_pkg::SPBASE,
  parameter int NSPBANK = 4
) (
  input  logic                         rst_i,
  input  logic                         clk_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  Instruction                   ir,
  input  logic [2:0]                   sp_sel,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NPORTS-1:0][REGW-1:0]  rs,
  output Instruction                   out_ir,
  output logic                         hazard,
  input  logic                         wr_set_v,
  input  logic [REGW-1:0]              wr_set_r,
  input  logic                         wr_clr_v,
  input  logic [REGW-1:0]              wr_clr_r
);
  logic full, fire, accept;
  logic [NPORTS-1:0][REGW-1:0] rs_d;
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    thor2022_src_remap #(
      .PORT(p), .REGW(REGW), .SPREG(SPREG), .SPBASE(SPBASE), .NSPBANK(NSPBANK)
    ) u_remap (
      .ir(ir), .sp_sel(sp_sel), .idx(rs_d[p])
    );
  end
  assign fire = out_valid & out_ready;
  assign in_ready = ~full | fire;
  assign accept = in_valid & in_ready & ~flush;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full <= 1'b0;
      rs <= '0;
      out_ir <= '0;
    end else begin
      full <= ~flush & (accept | (full & ~fire));
      if (accept) begin
        rs <= rs_d;
        out_ir <= ir;
      end
    end
  end
`ifdef THOR2022_REGSEL_SCOREBOARD_EN
  localparam int NREG = 2 ** REGW;
  logic [NREG-1:0] busy, set_m, clr_m;
  logic busy_hit;
  always_comb begin
    set_m = (wr_set_v && wr_set_r != '0) ? NREG'(1) << wr_set_r : '0;
    clr_m = wr_clr_v ? NREG'(1) << wr_clr_r : '0;
    busy_hit = 1'b0;
    for (int k = 0; k < NPORTS; k++) busy_hit = busy_hit | busy[rs[k]];
  end
  // set is applied after clear so a same-cycle set/clear leaves the register busy
  always_ff @(posedge clk_i) busy <= rst_i ? '0 : (busy & ~clr_m) | set_m;
  assign hazard = full & busy_hit;
  assign out_valid = full & ~busy_hit;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_set_v, wr_set_r, wr_clr_v, wr_clr_r};
  assign hazard = 1'b0;
  assign out_valid = full;
`endif
endmodule

// File: tb/tb_thor2022_regsel_stage.sv
// tb_thor2022_regsel_stage: directed and randomized checks against a behavioural model
module tb_thor2022_regsel_stage;
  localparam int NP = 3;
  localparam int RW = 6;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, flush, wr_set_v, wr_clr_v;
  logic in_ready, out_valid, hazard;
  logic [31:0] ir, out_ir;
  logic [2:0] sp_sel;
  logic [RW-1:0] wr_set_r, wr_clr_r;
  logic [NP-1:0][RW-1:0] rs;
  int tests = 0, fails = 0;
  bit m_full;
  logic [NP-1:0][RW-1:0] m_rs;
  logic [31:0] m_ir;
  bit m_busy [64];

  always #5 clk = ~clk;

  thor2022_regsel_stage dut (
    .rst_i(rst), .clk_i(clk), .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
    .sp_sel(sp_sel), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .rs(rs), .out_ir(out_ir), .hazard(hazard),
    .wr_set_v(wr_set_v), .wr_set_r(wr_set_r), .wr_clr_v(wr_clr_v), .wr_clr_r(wr_clr_r)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r3w(int op, int a, int b, int c);
    return 32'(op + (a << 7) + (b << 13) + (c << 19));
  endfunction

  function automatic logic [31:0] r2w(int op, int a, int b, int c);
    return 32'(op + (a << 12) + (b << 17) + (c << 22));
  endfunction

  function automatic logic [RW-1:0] ref_src(logic [31:0] w, logic [2:0] sel, int k);
    int idx, op, f;
    op = int'(w[6:0]);
    f = int'(w[31:27]);
    if (op == 2) idx = int'((w >> (7 + 6 * k)) & 32'd63);
    else if (op == 82 && k == 1) idx = (f <= 2) ? 32 + int'(w[17:15]) : 0;
    else idx = int'((w >> (12 + 5 * k)) & 32'd31);
    if (idx == 31 && sel >= 1 && sel <= 4) idx = 44 + int'(sel) - 1;
    return RW'(idx);
  endfunction

  function automatic bit busy_hit();
    bit h = 0;
    for (int k = 0; k < NP; k++) h |= m_busy[m_rs[k]];
`ifdef THOR2022_REGSEL_SCOREBOARD_EN
    return h;
`else
    return h & 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_full = 0;
    m_rs = '0;
    m_ir = '0;
    for (int i = 0; i < 64; i++) m_busy[i] = 0;
  endtask

  task automatic step();
    bit hz, ov, rdy;
    #3;
    hz = m_full && busy_hit();
    ov = m_full && !hz;
    rdy = !m_full || (ov && out_ready);
    chk("out_valid", out_valid, ov);
    chk("hazard", hazard, hz);
    chk("in_ready", in_ready, rdy);
    chk("rs", rs, m_rs);
    chk("out_ir", out_ir, m_ir);
    if (rst) model_reset();
    else begin
      if (wr_clr_v) m_busy[wr_clr_r] = 0;
      if (wr_set_v && wr_set_r != 0) m_busy[wr_set_r] = 1;
      if (flush) m_full = 0;
      else if (in_valid && rdy) begin
        m_full = 1;
        for (int k = 0; k < NP; k++) m_rs[k] = ref_src(ir, sp_sel, k);
        m_ir = ir;
      end else if (ov && out_ready) m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; flush = 0; ir = '0; sp_sel = '0;
    wr_set_v = 0; wr_set_r = '0; wr_clr_v = 0; wr_clr_r = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    chk("rst_rs", rs, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    // R2 with both SP ports remapped to bank 2
    in_valid = 1; out_ready = 0; ir = r3w(2, 31, 5, 31); sp_sel = 2;
    step();
    in_valid = 0;
    chk("r2_sp_rs", rs, {6'd45, 6'd5, 6'd45});
    chk("r2_sp_valid", out_valid, 1);
    out_ready = 1;
    step();
    in_valid = 1; ir = 32'(82 + (1 << 27) + (3 << 15)); sp_sel = 0;
    step();
    chk("vmfirst_rs1", rs[1], 35);
    ir = 32'(82 + (7 << 27) + (3 << 15));
    step();
    chk("vm_other_rs1", rs[1], 0);
    ir = r2w(5, 0, 31, 0); sp_sel = 6;
    step();
    chk("sp_oob_rs1", rs[1], 31);
    in_valid = 0;
    step();
    // busy register blocks then releases one cycle after clear
    out_ready = 0; wr_set_v = 1; wr_set_r = 7;
    step();
    wr_set_v = 0; in_valid = 1; ir = r2w(5, 0, 7, 0); sp_sel = 0;
    step();
    in_valid = 0;
`ifdef THOR2022_REGSEL_SCOREBOARD_EN
    chk("haz7_hazard", hazard, 1);
    chk("haz7_valid", out_valid, 0);
`else
    chk("nosb_hazard", hazard, 0);
    chk("nosb_valid", out_valid, 1);
`endif
    step();
    wr_clr_v = 1; wr_clr_r = 7;
    step();
    wr_clr_v = 0;
    chk("clr7_valid", out_valid, 1);
    out_ready = 1;
    step();
    out_ready = 0; wr_set_v = 1; wr_set_r = 9; wr_clr_v = 1; wr_clr_r = 9;
    step();
    wr_set_v = 0; wr_clr_v = 0; in_valid = 1; ir = r2w(5, 9, 0, 0);
    step();
    in_valid = 0;
`ifdef THOR2022_REGSEL_SCOREBOARD_EN
    chk("setclr9_hazard", hazard, 1);
`else
    chk("setclr9_hazard", hazard, 0);
`endif
    wr_clr_v = 1; wr_clr_r = 9;
    step();
    wr_clr_v = 0; out_ready = 1;
    step();
    wr_set_v = 1; wr_set_r = 0; in_valid = 1; ir = r2w(5, 0, 0, 0);
    step();
    wr_set_v = 0; in_valid = 0;
    chk("r0_hazard", hazard, 0);
    chk("r0_valid", out_valid, 1);
    step();
    // stall holds the stage, then flush drops it without capture
    out_ready = 0; in_valid = 1; ir = r3w(2, 1, 2, 3);
    step();
    ir = r3w(2, 4, 5, 6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_rs", rs, {6'd3, 6'd2, 6'd1});
    end
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    wr_set_v = 1; wr_set_r = 7;
    step();
    wr_set_v = 0; in_valid = 1; ir = r2w(5, 0, 7, 0);
    step();
    in_valid = 0; rst = 1;
    step();
    rst = 0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_rs", rs, 0);
    in_valid = 1;
    step();
    in_valid = 0;
    chk("post_rst_hazard", hazard, 0);
    chk("post_rst_valid", out_valid, 1);
    for (int n = 0; n < 500; n++) begin
      rst = $urandom_range(99) == 0;
      in_valid = $urandom_range(9) < 7;
      out_ready = $urandom_range(9) < 7;
      flush = $urandom_range(19) == 0;
      sp_sel = 3'($urandom_range(7));
      ir = $urandom;
      case ($urandom_range(3))
        0, 1: ir[6:0] = 7'd2;
        2: begin ir[6:0] = 7'd82; ir[31:27] = 5'($urandom_range(4)); end
        default: ;
      endcase
      wr_set_v = $urandom_range(4) == 0;
      wr_set_r = $urandom_range(1) ? m_rs[$urandom_range(NP - 1)] : RW'($urandom_range(63));
      wr_clr_v = $urandom_range(2) == 0;
      wr_clr_r = $urandom_range(1) ? m_rs[$urandom_range(NP - 1)] : RW'($urandom_range(63));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
